// File: rtl/z_stack.sv
// -----------------------------------------------------------------------------
// z_stack
//
// LIFO store for per-layer pre-activation vectors (z). During the forward pass
// it captures one z vector per layer. Once LAYER_NUM entries are held it
// replays them last layer first, each entry presented as a (layer, z) pair on
// two independent ready/valid channels that feed the weight controller.
//
// Optional feature (macro ZSTACK_EARLY_DRAIN_EN):
//   Adds input drain_req. In FILL with at least one entry stored, drain_req
//   starts the replay early from the most recently pushed layer. A push that
//   fires in the same cycle is stored before the replay starts.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   drain_req    in   early replay request (only with ZSTACK_EARLY_DRAIN_EN)
//   z_in         in   forward-pass z vector
//   z_in_valid   in   z_in valid
//   z_in_ready   out  stack accepting pushes (FILL state)
//   z            out  replayed z vector
//   z_valid      out  z valid
//   z_ready      in   z accepted
//   layer        out  layer address of the presented entry
//   layer_valid  out  layer valid
//   layer_ready  in   layer accepted
//   count        out  entries currently stored
//   draining     out  high while replaying (DRAIN state)
// -----------------------------------------------------------------------------
module z_stack #(
   parameter int NEURON_NUM          = 5,
   parameter int NEURON_OUTPUT_WIDTH = 10,
   parameter int LAYER_ADDR_WIDTH    = 2,
   parameter int LAYER_NUM           = 4
) (
   input  logic                                      clk,
   input  logic                                      rst,
`ifdef ZSTACK_EARLY_DRAIN_EN
   input  logic                                      drain_req,
`endif
   input  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] z_in,
   input  logic                                      z_in_valid,
   output logic                                      z_in_ready,
   output logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0] z,
   output logic                                      z_valid,
   input  logic                                      z_ready,
   output logic [LAYER_ADDR_WIDTH-1:0]               layer,
   output logic                                      layer_valid,
   input  logic                                      layer_ready,
   output logic [LAYER_ADDR_WIDTH:0]                 count,
   output logic                                      draining
);

   localparam int ZW  = NEURON_NUM * NEURON_OUTPUT_WIDTH;
   localparam int PW  = LAYER_ADDR_WIDTH + 1;
   localparam logic [PW-1:0] LP_LAYER_NUM = PW'(LAYER_NUM);

   typedef enum logic {
      ST_FILL,
      ST_DRAIN
   } state_t;

   state_t                        r_state;
   logic [PW-1:0]                 r_ptr;
   logic [ZW-1:0]                 r_mem [LAYER_NUM];
   logic                          r_z_sent;
   logic                          r_layer_sent;

   logic                          w_draining;
   logic                          w_push;
   logic                          w_drain_req;
   logic                          w_z_fire;
   logic                          w_layer_fire;
   logic                          w_retire;
   logic [PW-1:0]                 w_ptr_inc;
   logic [LAYER_ADDR_WIDTH-1:0]   w_top_idx;

`ifdef ZSTACK_EARLY_DRAIN_EN
   assign w_drain_req = drain_req;
`else
   assign w_drain_req = 1'b0;
`endif

   assign w_draining = (r_state == ST_DRAIN);
   assign w_push     = z_in_valid & ~w_draining;
   assign w_ptr_inc  = r_ptr + PW'(1);

   // Top-of-stack index. The low bits are enough: in DRAIN ptr is in
   // 1..LAYER_NUM, so ptr-1 always fits in LAYER_ADDR_WIDTH bits.
   assign w_top_idx  = r_ptr[LAYER_ADDR_WIDTH-1:0] - LAYER_ADDR_WIDTH'(1);

   // Fork handshake: each channel fires at most once per entry; the entry
   // retires once both have fired, whether in the same cycle or not.
   assign w_z_fire     = w_draining & ~r_z_sent     & z_ready;
   assign w_layer_fire = w_draining & ~r_layer_sent & layer_ready;
   assign w_retire     = w_draining & (r_z_sent | w_z_fire)
                                    & (r_layer_sent | w_layer_fire);

   // Outputs decode registered state only, so they settle to reset values
   // as soon as the asynchronous reset clears the registers.
   assign z_in_ready  = ~w_draining;
   assign draining    = w_draining;
   assign count       = r_ptr;
   assign z_valid     = w_draining & ~r_z_sent;
   assign layer_valid = w_draining & ~r_layer_sent;
   assign z           = w_draining ? r_mem[w_top_idx] : '0;
   assign layer       = w_draining ? w_top_idx : '0;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_FILL;
         r_ptr        <= '0;
         r_z_sent     <= 1'b0;
         r_layer_sent <= 1'b0;
         // NOTE: the storage array is cleared on reset on purpose so that z
         // never carries data from before the reset; this keeps it in flops.
         for (int i = 0; i < LAYER_NUM; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_FILL: begin
               if (w_push) begin
                  r_mem[r_ptr[LAYER_ADDR_WIDTH-1:0]] <= z_in;
                  r_ptr <= w_ptr_inc;
                  // An early drain request with a push stores the push first.
                  if ((w_ptr_inc == LP_LAYER_NUM) || w_drain_req) begin
                     r_state <= ST_DRAIN;
                  end
               end else if (w_drain_req && (r_ptr != '0)) begin
                  r_state <= ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               if (w_retire) begin
                  r_z_sent     <= 1'b0;
                  r_layer_sent <= 1'b0;
                  r_ptr        <= r_ptr - PW'(1);
                  if (r_ptr == PW'(1)) begin
                     r_state <= ST_FILL;
                  end
               end else begin
                  r_z_sent     <= r_z_sent     | w_z_fire;
                  r_layer_sent <= r_layer_sent | w_layer_fire;
               end
            end

            default: begin
               r_state <= ST_FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z_stack.sv
// -----------------------------------------------------------------------------
// tb_z_stack
//
// Directed bench for z_stack with the default parameters (5 x 10-bit cells,
// 4 layers). A vector table covers two back-to-back full passes with the
// push side held valid throughout; hand-written sequences cover split
// acceptance on the fork handshake, asynchronous reset mid-replay and, when
// ZSTACK_EARLY_DRAIN_EN is defined, the early drain request.
//
// Inputs are driven on the falling edge; outputs are checked 1 ns later,
// before the next rising edge applies the inputs.
// -----------------------------------------------------------------------------
module tb_z_stack;

   localparam int ZW = 50;

   logic            clk;
   logic            rst;
   logic [ZW-1:0]   z_in;
   logic            z_in_valid;
   logic            z_in_ready;
   logic [ZW-1:0]   z;
   logic            z_valid;
   logic            z_ready;
   logic [1:0]      layer;
   logic            layer_valid;
   logic            layer_ready;
   logic [2:0]      count;
   logic            draining;
`ifdef ZSTACK_EARLY_DRAIN_EN
   logic            drain_req;
`endif

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [ZW-1:0] VA = 50'h0_AAAA_0000_0001;
   localparam logic [ZW-1:0] VB = 50'h1_BBBB_0000_0002;
   localparam logic [ZW-1:0] VC = 50'h2_CCCC_0000_0003;
   localparam logic [ZW-1:0] VD = 50'h3_DDDD_0000_0004;
   localparam logic [ZW-1:0] VE = 50'h0_EEEE_0000_0005;
   localparam logic [ZW-1:0] VF = 50'h1_0F0F_0000_0006;
   localparam logic [ZW-1:0] VG = 50'h2_0606_0000_0007;
   localparam logic [ZW-1:0] VH = 50'h3_0808_0000_0008;
   localparam logic [ZW-1:0] VI = 50'h0_0909_0000_0009;

   z_stack dut (
      .clk         (clk),
      .rst         (rst),
`ifdef ZSTACK_EARLY_DRAIN_EN
      .drain_req   (drain_req),
`endif
      .z_in        (z_in),
      .z_in_valid  (z_in_valid),
      .z_in_ready  (z_in_ready),
      .z           (z),
      .z_valid     (z_valid),
      .z_ready     (z_ready),
      .layer       (layer),
      .layer_valid (layer_valid),
      .layer_ready (layer_ready),
      .count       (count),
      .draining    (draining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [ZW-1:0] d;
      logic          zr;
      logic          lr;
      logic          e_rdy;
      logic          e_zv;
      logic [ZW-1:0] e_z;
      logic          e_lv;
      logic [1:0]    e_l;
      logic [2:0]    e_cnt;
      logic          e_dr;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_total++;
      if (act === exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [ZW-1:0] d, input logic zr, input logic lr);
      z_in_valid  = v;
      z_in        = d;
      z_ready     = zr;
      layer_ready = lr;
   endtask

   // Checks all outputs; z and layer only while their valid is expected high.
   task automatic expect_out(input string tag, input logic e_rdy, input logic e_zv,
                             input logic [ZW-1:0] e_z, input logic e_lv, input logic [1:0] e_l,
                             input logic [2:0] e_cnt, input logic e_dr);
      check({tag, ".z_in_ready"},  64'(z_in_ready),  64'(e_rdy));
      check({tag, ".z_valid"},     64'(z_valid),     64'(e_zv));
      check({tag, ".layer_valid"}, 64'(layer_valid), 64'(e_lv));
      check({tag, ".count"},       64'(count),       64'(e_cnt));
      check({tag, ".draining"},    64'(draining),    64'(e_dr));
      if (e_zv) check({tag, ".z"},     64'(z),     64'(e_z));
      if (e_lv) check({tag, ".layer"}, 64'(layer), 64'(e_l));
   endtask

   // One cycle: drive at the falling edge, check 1 ns later.
   task automatic cyc(input string tag, input logic v, input logic [ZW-1:0] d,
                      input logic zr, input logic lr,
                      input logic e_rdy, input logic e_zv, input logic [ZW-1:0] e_z,
                      input logic e_lv, input logic [1:0] e_l, input logic [2:0] e_cnt,
                      input logic e_dr);
      @(negedge clk);
      drive(v, d, zr, lr);
      #1;
      expect_out(tag, e_rdy, e_zv, e_z, e_lv, e_l, e_cnt, e_dr);
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
`ifdef ZSTACK_EARLY_DRAIN_EN
      drain_req = 1'b0;
`endif

      // Two full passes back to back. Rows 4-7 and 12-15 hold z_in_valid with
      // VE while replaying; it must never be captured.
      //          v     d   zr    lr    rdy   zv    z   lv    l     cnt   dr
      vecs[0]  = '{1'b1, VA, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0};
      vecs[1]  = '{1'b1, VB, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd1, 1'b0};
      vecs[2]  = '{1'b1, VC, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd2, 1'b0};
      vecs[3]  = '{1'b1, VD, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd3, 1'b0};
      vecs[4]  = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VD, 1'b1, 2'd3, 3'd4, 1'b1};
      vecs[5]  = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VC, 1'b1, 2'd2, 3'd3, 1'b1};
      vecs[6]  = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VB, 1'b1, 2'd1, 3'd2, 1'b1};
      vecs[7]  = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VA, 1'b1, 2'd0, 3'd1, 1'b1};
      vecs[8]  = '{1'b1, VD, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0};
      vecs[9]  = '{1'b1, VC, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd1, 1'b0};
      vecs[10] = '{1'b1, VB, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd2, 1'b0};
      vecs[11] = '{1'b1, VA, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd3, 1'b0};
      vecs[12] = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VA, 1'b1, 2'd3, 3'd4, 1'b1};
      vecs[13] = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VB, 1'b1, 2'd2, 3'd3, 1'b1};
      vecs[14] = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VC, 1'b1, 2'd1, 3'd2, 1'b1};
      vecs[15] = '{1'b1, VE, 1'b1, 1'b1, 1'b0, 1'b1, VD, 1'b1, 2'd0, 3'd1, 1'b1};
      vecs[16] = '{1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0};

      // Values held in reset.
      #3;
      check("reset.z_in_ready",  64'(z_in_ready),  64'd1);
      check("reset.z_valid",     64'(z_valid),     64'd0);
      check("reset.layer_valid", 64'(layer_valid), 64'd0);
      check("reset.count",       64'(count),       64'd0);
      check("reset.draining",    64'(draining),    64'd0);
      check("reset.z",           64'(z),           64'd0);
      check("reset.layer",       64'(layer),       64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 17; i++) begin
         cyc($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].zr, vecs[i].lr,
             vecs[i].e_rdy, vecs[i].e_zv, vecs[i].e_z, vecs[i].e_lv, vecs[i].e_l,
             vecs[i].e_cnt, vecs[i].e_dr);
      end

      // Split acceptance: layer taken first, z held off for three cycles.
      cyc("split.push0", 1'b1, VA, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0);
      cyc("split.push1", 1'b1, VB, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd1, 1'b0);
      cyc("split.push2", 1'b1, VC, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd2, 1'b0);
      cyc("split.push3", 1'b1, VD, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd3, 1'b0);
      cyc("split.s0", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, VD, 1'b1, 2'd3, 3'd4, 1'b1);
      cyc("split.s1", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, VD, 1'b0, 2'd3, 3'd4, 1'b1);
      cyc("split.s2", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, VD, 1'b0, 2'd3, 3'd4, 1'b1);
      cyc("split.s3", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, VD, 1'b0, 2'd3, 3'd4, 1'b1);
      // Reverse order on the next entry: z first, layer two cycles later.
      cyc("split.s4", 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, VC, 1'b1, 2'd2, 3'd3, 1'b1);
      cyc("split.s5", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, VC, 1'b1, 2'd2, 3'd3, 1'b1);
      cyc("split.s6", 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, VC, 1'b1, 2'd2, 3'd3, 1'b1);
      cyc("split.s7", 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, VB, 1'b1, 2'd1, 3'd2, 1'b1);

      // Asynchronous reset with two entries still pending, between clock edges.
      #1;
      rst = 1'b0;
      #1;
      check("arst.count",       64'(count),       64'd0);
      check("arst.z_valid",     64'(z_valid),     64'd0);
      check("arst.layer_valid", 64'(layer_valid), 64'd0);
      check("arst.z_in_ready",  64'(z_in_ready),  64'd1);
      check("arst.draining",    64'(draining),    64'd0);
      check("arst.z",           64'(z),           64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Fresh pass after reset: the first push must come back as layer 0.
      cyc("rfill.0", 1'b1, VF, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0);
      cyc("rfill.1", 1'b1, VG, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd1, 1'b0);
      cyc("rfill.2", 1'b1, VH, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd2, 1'b0);
      cyc("rfill.3", 1'b1, VI, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd3, 1'b0);
      cyc("rdrain.3", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, VI, 1'b1, 2'd3, 3'd4, 1'b1);
      cyc("rdrain.2", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, VH, 1'b1, 2'd2, 3'd3, 1'b1);
      cyc("rdrain.1", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, VG, 1'b1, 2'd1, 3'd2, 1'b1);
      cyc("rdrain.0", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, VF, 1'b1, 2'd0, 3'd1, 1'b1);
      cyc("rdone",    1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0);

`ifdef ZSTACK_EARLY_DRAIN_EN
      // Early drain after two pushes.
      cyc("early.push0", 1'b1, VA, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0);
      cyc("early.push1", 1'b1, VB, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd1, 1'b0);
      @(negedge clk);
      drive(1'b0, '0, 1'b0, 1'b0);
      drain_req = 1'b1;
      #1;
      expect_out("early.req", 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd2, 1'b0);
      @(negedge clk);
      drain_req = 1'b0;
      drive(1'b0, '0, 1'b1, 1'b1);
      #1;
      expect_out("early.d1", 1'b0, 1'b1, VB, 1'b1, 2'd1, 3'd2, 1'b1);
      cyc("early.d0", 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, VA, 1'b1, 2'd0, 3'd1, 1'b1);
      cyc("early.done", 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0);
      // Request with nothing stored is ignored.
      @(negedge clk);
      drain_req = 1'b1;
      #1;
      expect_out("early.empty_req", 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0);
      @(negedge clk);
      drain_req = 1'b0;
      #1;
      expect_out("early.empty_after", 1'b1, 1'b0, '0, 1'b0, 2'd0, 3'd0, 1'b0);
`endif

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
